// File: rtl/ula_arbiter.sv
//==============================================================================
// ula_arbiter : round-robin arbiter sharing one 4-bit ULA between two requesters
// Revision    : 1.0
//==============================================================================
`default_nettype none

//------------------------------------------------------------------------------
// ula_74181 : 4-bit combinational ULA; m=1 logic, m=0 arithmetic
// Revision  : 1.0
//------------------------------------------------------------------------------
module ula_74181 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_c_in,
    output logic [3:0] o_f,
    output logic       o_c_out,
    output logic       o_a_eq_b
);
    logic [3:0] w_x;
    logic [3:0] w_logic;
    logic [4:0] w_sum;

    always_comb begin
        w_x     = 4'h0;
        w_logic = 4'h0;
        case (i_s)
            4'h0: begin w_logic = ~i_a;          w_x = 4'h0;           end
            4'h1: begin w_logic = ~(i_a | i_b);  w_x = i_a & i_b;      end
            4'h2: begin w_logic = ~i_a & i_b;    w_x = i_a & ~i_b;     end
            4'h3: begin w_logic = 4'h0;          w_x = 4'hF;           end
            4'h4: begin w_logic = ~(i_a & i_b);  w_x = i_a | i_b;      end
            4'h5: begin w_logic = ~i_b;          w_x = i_b;            end
            4'h6: begin w_logic = i_a ^ i_b;     w_x = i_a;            end
            4'h7: begin w_logic = i_a & ~i_b;    w_x = i_a | ~i_b;     end
            // Upper half: A minus Y with carry-in as not-borrow, X = ~Y.
            4'h8: begin w_logic = i_a & i_b;     w_x = ~i_b;           end
            4'h9: begin w_logic = ~(i_a ^ i_b);  w_x = ~(i_a & i_b);   end
            4'hA: begin w_logic = i_b;           w_x = ~(i_a | i_b);   end
            4'hB: begin w_logic = ~i_a | i_b;    w_x = ~i_a;           end
            4'hC: begin w_logic = 4'hF;          w_x = 4'hF;           end
            4'hD: begin w_logic = i_a | ~i_b;    w_x = ~(i_a & ~i_b);  end
            4'hE: begin w_logic = i_a | i_b;     w_x = 4'h0;           end
            default: begin w_logic = i_a;        w_x = i_a | ~i_b;     end
        endcase
    end

    assign w_sum    = {1'b0, i_a} + {1'b0, w_x} + {4'b0000, i_c_in};
    assign o_f      = i_m ? w_logic : w_sum[3:0];
    // Subtract-style functions report borrow rather than carry.
    assign o_c_out  = i_m ? 1'b0 : (w_sum[4] ^ i_s[3]);
    assign o_a_eq_b = (i_a == i_b);
endmodule

module ula_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       a0,
    input  logic [3:0]       b0,
    input  logic [3:0]       a1,
    input  logic [3:0]       b1,
    input  logic [3:0]       s0,
    input  logic [3:0]       s1,
    input  logic             m0,
    input  logic             m1,
    input  logic             c_in0,
    input  logic             c_in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_gid;
    logic [3:0]       r_a, r_b, r_s;
    logic             r_m, r_cin;
    logic             r_valid, r_rsp_id, r_c_out, r_a_eq_b;
    logic [3:0]       r_f;
    logic [CNT_W-1:0] r_cnt;
    logic             w_grant, w_pick1, w_xfer;
    logic [3:0]       w_f;
    logic             w_c_out, w_a_eq_b;

    // Requester 1 wins when alone, or on a tie when 0 was granted last.
    assign w_pick1 = req1 & (~req0 | ~r_last);
    assign w_grant = (r_state == ST_IDLE) & (req0 | req1);
    assign w_xfer  = (r_state == ST_RESP) & rsp_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_xfer) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_gid    <= 1'b0;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_s      <= 4'h0;
            r_m      <= 1'b0;
            r_cin    <= 1'b0;
            r_valid  <= 1'b0;
            r_rsp_id <= 1'b0;
            r_f      <= 4'h0;
            r_c_out  <= 1'b0;
            r_a_eq_b <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_last <= w_pick1;
                r_gid  <= w_pick1;
                r_a    <= w_pick1 ? a1    : a0;
                r_b    <= w_pick1 ? b1    : b0;
                r_s    <= w_pick1 ? s1    : s0;
                r_m    <= w_pick1 ? m1    : m0;
                r_cin  <= w_pick1 ? c_in1 : c_in0;
            end
            if (r_state == ST_EXEC) begin
                r_f      <= w_f;
                r_c_out  <= w_c_out;
                r_a_eq_b <= w_a_eq_b;
                r_rsp_id <= r_gid;
                r_valid  <= 1'b1;
            end
            if (w_xfer) begin
                r_valid <= 1'b0;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    ula_74181 u_ula (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_s      (r_s),
        .i_m      (r_m),
        .i_c_in   (r_cin),
        .o_f      (w_f),
        .o_c_out  (w_c_out),
        .o_a_eq_b (w_a_eq_b)
    );

    // Grants are combinational so capture happens on the edge ending the pulse.
    assign gnt0      = w_grant & ~w_pick1 & ~rst;
    assign gnt1      = w_grant &  w_pick1 & ~rst;
    assign rsp_valid = r_valid;
    assign rsp_id    = r_rsp_id;
    assign f         = r_f;
    assign c_out     = r_c_out;
    assign a_eq_b    = r_a_eq_b;
    assign busy      = (r_state != ST_IDLE);
    assign op_cnt    = r_cnt;
endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
//==============================================================================
// tb_ula_arbiter : directed + scoreboard bench for ula_arbiter
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_ula_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, m0, m1, c_in0, c_in1, rsp_ready;
    logic [3:0] a0, b0, a1, b1, s0, s1;
    logic       gnt0, gnt1, rsp_valid, rsp_id, c_out, a_eq_b, busy;
    logic [3:0] f;
    logic [7:0] op_cnt;

    typedef struct packed {
        logic       id;
        logic [3:0] f;
        logic       c;
        logic       eq;
        logic       chk_c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    ula_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .s0(s0), .s1(s1),
        .m0(m0), .m1(m1), .c_in0(c_in0), .c_in1(c_in1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .f(f), .c_out(c_out), .a_eq_b(a_eq_b),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        exp_t e;
        int   r;
        e.id = id; e.eq = (a == b); e.c = 1'b0; e.f = 4'h0; e.chk_c = 1'b1;
        if (m) begin
            e.f = a & b;
            e.chk_c = 1'b0;
        end else if (s == 4'h5) begin
            r = int'(a) + int'(b) + int'(cin);
            e.f = r[3:0];
            e.c = (r > 15);
        end else begin
            r = int'(a) - int'(b) - (cin ? 0 : 1);
            e.f = r[3:0];
            e.c = (r < 0);
        end
        return e;
    endfunction

    task automatic set_ops(input logic idx, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s, input logic m, input logic cin);
        if (idx) begin a1 = a; b1 = b; s1 = s; m1 = m; c_in1 = cin; end
        else     begin a0 = a; b0 = b; s0 = s; m0 = m; c_in0 = cin; end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s_sb: observed response expected none queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, rsp_id, e.id);
            chk({tag, "_f"},  f,      e.f);
            chk({tag, "_eq"}, a_eq_b, e.eq);
            if (e.chk_c) chk({tag, "_cout"}, c_out, e.c);
        end
    endtask

    // Full transaction: request, grant, 2-cycle latency, response, transfer.
    task automatic do_op(input string tag, input logic idx, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] s, input logic m,
                         input logic cin, input exp_t e);
        int k;
        sb.push_back(e);
        @(posedge clk); #1;
        set_ops(idx, a, b, s, m, cin);
        if (idx) req1 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        k = 0;
        while (!(idx ? gnt1 : gnt0) && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_gnt"}, idx ? gnt1 : gnt0, 1'b1);
        chk({tag, "_gnt_other"}, idx ? gnt0 : gnt1, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk({tag, "_exec_valid"}, rsp_valid, 1'b0);
        chk({tag, "_exec_busy"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_lat_valid"}, rsp_valid, 1'b1);
        if (rsp_valid) check_rsp(tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        chk({tag, "_post_valid"}, rsp_valid, 1'b0);
        chk({tag, "_opcnt"}, op_cnt, exp_cnt[7:0]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        sb.delete();
    endtask

    initial begin
        exp_t    e;
        logic    idx, mm, cc;
        logic [3:0] aa, bb, ss;
        logic [3:0] held_f;
        int      n, k;

        rst = 1'b1; req0 = 0; req1 = 0; rsp_ready = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; s0 = 0; s1 = 0;
        m0 = 0; m1 = 0; c_in0 = 0; c_in1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);      chk("rst_gnt1", gnt1, 0);
        chk("rst_valid", rsp_valid, 0); chk("rst_id", rsp_id, 0);
        chk("rst_f", f, 4'h0);          chk("rst_cout", c_out, 0);
        chk("rst_eq", a_eq_b, 0);       chk("rst_busy", busy, 0);
        chk("rst_opcnt", op_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_nogrant", {gnt0, gnt1, busy}, 3'b000);

        e = '{id:1'b0, f:4'h2, c:1'b0, eq:1'b0, chk_c:1'b0};
        do_op("logic_and", 1'b0, 4'hA, 4'h6, 4'b1000, 1'b1, 1'b0, e);
        e = '{id:1'b1, f:4'h0, c:1'b1, eq:1'b0, chk_c:1'b1};
        do_op("arith_add", 1'b1, 4'hF, 4'h1, 4'b0101, 1'b0, 1'b0, e);
        e = '{id:1'b0, f:4'h2, c:1'b0, eq:1'b0, chk_c:1'b1};
        do_op("arith_sub", 1'b0, 4'h5, 4'h3, 4'b1000, 1'b0, 1'b1, e);
        e = '{id:1'b0, f:4'h0, c:1'b0, eq:1'b1, chk_c:1'b1};
        do_op("cmp_eq", 1'b0, 4'h3, 4'h3, 4'b1000, 1'b0, 1'b1, e);

        for (int i = 0; i < 6; i++) begin
            idx = i[0];
            aa = 4'($urandom); bb = 4'($urandom); cc = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       begin ss = 4'b1000; mm = 1'b1; end
                1:       begin ss = 4'b0101; mm = 1'b0; end
                default: begin ss = 4'b1000; mm = 1'b0; end
            endcase
            do_op("rand", idx, aa, bb, ss, mm, cc, model(idx, aa, bb, ss, mm, cc));
        end

        // Backpressure: held response, competing request ignored then withdrawn.
        @(posedge clk); #1;
        set_ops(1'b0, 4'hC, 4'h5, 4'b1000, 1'b1, 1'b0);
        req0 = 1'b1;
        @(negedge clk);
        chk("bp_gnt0", gnt0, 1'b1);
        @(posedge clk); #1; req0 = 1'b0;
        @(negedge clk); @(negedge clk);
        held_f = 4'h4;
        @(posedge clk); #1; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_f", f, held_f);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_nogrant", {gnt0, gnt1}, 2'b00);
        end
        @(posedge clk); #1; req1 = 1'b0;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0; exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("withdrawn_nogrant", {gnt0, gnt1, rsp_valid, busy}, 4'b0000);
        end
        chk("bp_opcnt", op_cnt, exp_cnt[7:0]);

        // Tie from reset: grants alternate 0,1,0,1 every 3 cycles.
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_gated_gnt", {gnt0, gnt1}, 2'b00);
        @(posedge clk); #1; rst = 1'b0;
        for (int kk = 0; kk < 10; kk++) begin
            @(negedge clk);
            chk("tie_gnt0", gnt0, (kk % 6) == 0);
            chk("tie_gnt1", gnt1, (kk % 6) == 3);
            if (kk == 2) chk("tie_id0", rsp_id, 1'b0);
            if (kk == 5) chk("tie_id1", rsp_id, 1'b1);
        end
        @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("tie_drain", {rsp_valid, busy}, 2'b00);

        // op_cnt wrap across 256 transfers.
        do_reset();
        req0 = 1'b1; rsp_ready = 1'b1;
        n = 0; k = 0;
        while (n < 255 && k < 2000) begin
            @(negedge clk); k++;
            if (rsp_valid) n++;
        end
        @(negedge clk);
        chk("wrap_255", op_cnt, 8'd255);
        while (n < 256 && k < 2000) begin
            @(negedge clk); k++;
            if (rsp_valid) n++;
        end
        @(posedge clk); #1; req0 = 1'b0;
        @(negedge clk);
        chk("wrap_0", op_cnt, 8'd0);
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during RESP abandons the op; pointer returns to favour req0.
        do_reset();
        e = '{id:1'b0, f:4'h1, c:1'b0, eq:1'b0, chk_c:1'b1};
        do_op("pre_rst", 1'b0, 4'h9, 4'h7, 4'b1000, 1'b0, 1'b0, e);
        @(posedge clk); #1;
        set_ops(1'b0, 4'h1, 4'h1, 4'b0101, 1'b0, 1'b0);
        req0 = 1'b1;
        @(negedge clk);
        chk("rr_gnt0", gnt0, 1'b1);
        @(posedge clk); #1; req0 = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rr_resp_valid", rsp_valid, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", rsp_valid, 1'b0);
        chk("async_opcnt", op_cnt, 8'd0);
        chk("async_busy", busy, 1'b0);
        chk("async_gnt", {gnt0, gnt1}, 2'b00);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt0", gnt0, 1'b1);
        chk("post_rst_gnt1", gnt1, 1'b0);
        @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
        sb.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
